// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types: FSM state, bubble encoding and the IF/ID slot layout.
// Decode consumes if_id_t directly, so field order is part of the stage contract.
package instr_fetch_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instr_mem read port, downstream control inputs and the IF/ID slot.
// FETCH_MISALIGN_CHECK_EN adds misaligned_fault/fault_addr.
interface instr_fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        halted;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misaligned_fault;
  logic [31:0] fault_addr;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, halted,
           misaligned_fault, fault_addr,
    input  imem_rdata, stall, redirect_valid, redirect_target, halt
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, halted,
           misaligned_fault, fault_addr,
    output imem_rdata, stall, redirect_valid, redirect_target, halt
  );
`else
  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, halted,
    input  imem_rdata, stall, redirect_valid, redirect_target, halt
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, halted,
    output imem_rdata, stall, redirect_valid, redirect_target, halt
  );
`endif

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC select: hold on halt/halted/stall, load redirect target, else +4.
// With FETCH_MISALIGN_CHECK_EN a misaligned redirect target holds the PC and is flagged.
module instr_fetch_pc_next (
  input  logic [31:0] pc_q,
  input  logic        halted,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic [31:0] pc_inc,
  output logic [31:0] pc_d
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  logic bad_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_target = (redirect_target[1:0] != 2'b00);
  assign misaligned = bad_target;
`else
  assign bad_target = 1'b0;
`endif

  // Modulo-2^32: the PC wraps from FFFF_FFFC to 0 silently.
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_inc;
    if (halted || halt) begin
      pc_d = pc_q;
    end else if (redirect_valid) begin
      pc_d = bad_target ? pc_q : redirect_target;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instr_mem combinationally and registers the IF/ID slot.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned redirects into a sticky halting fault.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_inc;
  logic [31:0]  pc_d;
  if_id_t       if_id_q;
  logic         halted_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic         misaligned;
  logic         fault_q;
  logic [31:0]  fault_addr_q;
`endif

  instr_fetch_pc_next u_pc_next (
    .pc_q            (pc_q),
    .halted          (state_q == HALTED),
    .halt            (bus.halt),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (bus.redirect_target),
    .stall           (bus.stall),
    .pc_inc          (pc_inc),
    .pc_d            (pc_d)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misaligned      (misaligned)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      if_id_q  <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd4};
      halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          pc_q <= pc_d;
          if (bus.halt) begin
            state_q        <= HALTED;
            halted_q       <= 1'b1;
            if_id_q.valid  <= 1'b0;
            if_id_q.instr  <= NOP_INSTR;
          end else if (bus.redirect_valid) begin
            // The word fetched this cycle is on the wrong path; kill it.
            if_id_q.valid <= 1'b0;
            if_id_q.instr <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misaligned) begin
              state_q      <= HALTED;
              halted_q     <= 1'b1;
              fault_q      <= 1'b1;
              fault_addr_q <= bus.redirect_target;
            end
`endif
          end else if (!bus.stall) begin
            if_id_q <= '{valid: 1'b1, instr: bus.imem_rdata, pc: pc_q, pc_plus4: pc_inc};
          end
        end
        HALTED: begin
          // Frozen until reset.
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = if_id_q.valid;
  assign bus.if_instr    = if_id_q.instr;
  assign bus.if_pc       = if_id_q.pc;
  assign bus.if_pc_plus4 = if_id_q.pc_plus4;
  assign bus.halted      = halted_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.misaligned_fault = fault_q;
  assign bus.fault_addr       = fault_addr_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench: two fetch stages (RESET_PC 0 and FFFF_FFFC) share directed then random stimulus.
// A behavioural model pushes expected post-edge state; a monitor pops and compares after each edge.
module tb_instr_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        halted;
    logic        fault;
    logic [31:0] faddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        halt = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  string phase = "init";

  exp_t q0[$];
  exp_t q1[$];

  // Model state per DUT.
  logic [31:0] m_pc[2];
  logic        m_halted[2];
  logic        m_valid[2];
  logic [31:0] m_instr[2];
  logic [31:0] m_ipc[2];
  logic [31:0] m_ipc4[2];
  logic        m_fault[2];
  logic [31:0] m_faddr[2];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h00002083;
      30'd1:   return 32'h00402103;
      30'd2:   return 32'h00400393;
      30'd3:   return 32'h0083a183;
      default: return {a[31:2], 2'b00} ^ 32'hA5C3_0F1B;
    endcase
  endfunction

  instr_fetch_if ifc0 ();
  instr_fetch_if ifc1 ();

  assign ifc0.imem_rdata      = mem_word(ifc0.imem_addr);
  assign ifc0.stall           = stall;
  assign ifc0.redirect_valid  = redirect_valid;
  assign ifc0.redirect_target = redirect_target;
  assign ifc0.halt            = halt;
  assign ifc1.imem_rdata      = mem_word(ifc1.imem_addr);
  assign ifc1.stall           = stall;
  assign ifc1.redirect_valid  = redirect_valid;
  assign ifc1.redirect_target = redirect_target;
  assign ifc1.halt            = halt;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP_W)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0.master)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP_W)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.master)
  );

  function automatic logic [31:0] reset_pc(input int id);
    return (id == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  // Applies one cycle of the fetch rules to the model of DUT id.
  task automatic model_edge(input int id);
    logic misaligned_redirect;
    misaligned_redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned_redirect = (redirect_target % 4) != 0;
`endif
    if (rst) begin
      m_pc[id] = reset_pc(id);
      m_halted[id] = 1'b0;
      m_valid[id] = 1'b0;
      m_instr[id] = NOP_W;
      m_ipc[id] = 32'd0;
      m_ipc4[id] = 32'd4;
      m_fault[id] = 1'b0;
      m_faddr[id] = 32'd0;
    end else if (m_halted[id]) begin
      // nothing moves
    end else if (halt) begin
      m_halted[id] = 1'b1;
      m_valid[id] = 1'b0;
      m_instr[id] = NOP_W;
    end else if (redirect_valid) begin
      m_valid[id] = 1'b0;
      m_instr[id] = NOP_W;
      if (misaligned_redirect) begin
        m_halted[id] = 1'b1;
        m_fault[id] = 1'b1;
        m_faddr[id] = redirect_target;
      end else begin
        m_pc[id] = redirect_target;
      end
    end else if (!stall) begin
      m_valid[id] = 1'b1;
      m_instr[id] = mem_word(m_pc[id]);
      m_ipc[id] = m_pc[id];
      m_ipc4[id] = m_pc[id] + 32'd4;
      m_pc[id] = m_pc[id] + 32'd4;
    end
  endtask

  function automatic exp_t model_view(input int id);
    exp_t e;
    e.addr = m_pc[id];
    e.valid = m_valid[id];
    e.instr = m_instr[id];
    e.pc = m_ipc[id];
    e.pc4 = m_ipc4[id];
    e.halted = m_halted[id];
    e.fault = m_fault[id];
    e.faddr = m_faddr[id];
    return e;
  endfunction

  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [31:0] t, input logic h);
    @(negedge clk);
    rst = r;
    stall = s;
    redirect_valid = rv;
    redirect_target = t;
    halt = h;
    model_edge(0);
    model_edge(1);
    q0.push_back(model_view(0));
    q1.push_back(model_view(1));
  endtask

  task automatic check(input int id, input exp_t got, input exp_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d: got addr=%h v=%b instr=%h pc=%h pc4=%h halted=%b fault=%b faddr=%h; want addr=%h v=%b instr=%h pc=%h pc4=%h halted=%b fault=%b faddr=%h",
               phase, id, got.addr, got.valid, got.instr, got.pc, got.pc4, got.halted,
               got.fault, got.faddr, want.addr, want.valid, want.instr, want.pc,
               want.pc4, want.halted, want.fault, want.faddr);
    end
  endtask

  // Monitor: the DUT presents a new IF/ID slot after every edge.
  initial begin
    exp_t a;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = '0;
        a.addr = ifc0.imem_addr;
        a.valid = ifc0.if_valid;
        a.instr = ifc0.if_instr;
        a.pc = ifc0.if_pc;
        a.pc4 = ifc0.if_pc_plus4;
        a.halted = ifc0.halted;
`ifdef FETCH_MISALIGN_CHECK_EN
        a.fault = ifc0.misaligned_fault;
        a.faddr = ifc0.fault_addr;
`endif
        check(0, a, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '0;
        a.addr = ifc1.imem_addr;
        a.valid = ifc1.if_valid;
        a.instr = ifc1.if_instr;
        a.pc = ifc1.if_pc;
        a.pc4 = ifc1.if_pc_plus4;
        a.halted = ifc1.halted;
`ifdef FETCH_MISALIGN_CHECK_EN
        a.fault = ifc1.misaligned_fault;
        a.faddr = ifc1.fault_addr;
`endif
        check(1, a, e);
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    phase = "reset";
    step(1, 0, 0, 32'd0, 0);
    step(1, 0, 0, 32'd0, 0);

    phase = "sequential";
    repeat (2) step(0, 0, 0, 32'd0, 0);
    phase = "stall";
    repeat (3) step(0, 1, 0, 32'd0, 0);
    phase = "resume";
    step(0, 0, 0, 32'd0, 0);
    phase = "redirect_stall";
    step(0, 1, 1, 32'd0, 0);
    phase = "after_redirect";
    repeat (5) step(0, 0, 0, 32'd0, 0);

    phase = "halt_priority";
    step(0, 1, 1, 32'd8, 1);
    phase = "halted_ignores";
    step(0, 0, 1, 32'd4, 0);
    step(0, 1, 0, 32'd0, 0);
    step(0, 0, 0, 32'd0, 0);
    phase = "reset_exit";
    step(1, 0, 0, 32'd0, 0);
    repeat (3) step(0, 0, 0, 32'd0, 0);
    phase = "reset_mid_stream";
    step(1, 0, 0, 32'd0, 0);
    repeat (2) step(0, 0, 0, 32'd0, 0);

    phase = "odd_redirect";
    step(0, 0, 1, 32'h0000_0006, 0);
    repeat (3) step(0, 0, 0, 32'd0, 0);
    step(1, 0, 0, 32'd0, 0);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) tgt = $urandom;
      else tgt = 32'($urandom_range(0, 15)) << 2;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), tgt, ($urandom_range(0, 39) == 0));
    end

    phase = "drain";
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
